instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
- Fetch stage of the 5-stage pipelined CPU.
- Owns the program counter and drives the byte address of the combinational instruction memory.
- Registers the returned word, together with PC+4, into the IF/ID pipeline register.
- Accepts stall requests from the hazard unit and redirect (branch/jump) requests from the EX/MEM stage.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded at reset.
- MEM_BYTES, 80, instruction memory size in bytes; fetch halts at or beyond this address.
- NOP_WORD, 32'h0000_0020, bubble instruction (add $zero,$zero,$zero) inserted into IF/ID.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  level; leaving IDLE requires start=1.
- stall  in  1  hazard unit: hold PC and IF/ID.
- redirect  in  1  take branch/jump this cycle.
- redirect_pc  in  32  byte target of redirect.
- imem_addr  out  32  byte address to instruction memory (equals pc).
- imem_instr  in  32  instruction word returned combinationally for imem_addr.
- if_id_instr  out  32  registered instruction to decode.
- if_id_pc4  out  32  registered PC+4 of that instruction.
- if_id_valid  out  1  1 = real instruction, 0 = bubble.
- pc  out  32  current PC.
- halted  out  1  1 in HALT state.

Behaviour:
- Reset, asynchronous on rst_n=0:
  - state=IDLE, pc=RESET_PC.
  - if_id_instr=NOP_WORD, if_id_pc4=0, if_id_valid=0, halted=0.
- imem_addr = pc, combinational.
- The fetched word for pc is captured at the next rising edge, giving 1-cycle latency from PC to IF/ID.
- States:
  - IDLE: pc holds; IF/ID loads a bubble every cycle. start=1 -> RUN at the next edge; the first fetch is from RESET_PC in RUN.
  - RUN: per-edge priority is redirect > stall > advance.
    - redirect=1: pc <= {redirect_pc[31:2],2'b00}; IF/ID <= bubble (wrong-path word squashed). Redirect overrides a simultaneous stall.
    - stall=1 (no redirect): pc and all IF/ID outputs hold unchanged.
    - Advance: IF/ID <= {imem_instr, pc+4, valid=1}; pc <= pc+4.
    - When pc >= MEM_BYTES at an edge with no redirect: -> HALT, IF/ID <= bubble, pc holds.
  - HALT: halted=1; IF/ID bubble each cycle; pc holds.
    - redirect with aligned target < MEM_BYTES: -> RUN, pc <= target.
    - Other redirects are ignored.
    - stall is ignored in HALT.
- start is ignored outside IDLE; deasserting start does not stop RUN.
- Arithmetic: pc+4 is 32-bit modulo; wrap-around is unreachable because HALT triggers first.
- Misaligned redirect targets are silently aligned (low 2 bits cleared).
- Reset asserted mid-operation: immediate return to the reset values regardless of stall/redirect; any in-flight IF/ID content is discarded.

Optional Feature:
- Macro FETCH_PERF_EN.
- Defined:
  - Adds outputs fetch_count[31:0] and squash_count[31:0], reset to 0.
  - fetch_count increments on each advance edge (valid word loaded).
  - squash_count increments on each redirect taken in RUN.
  - Both saturate at 32'hFFFF_FFFF.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package cpu_pkg holds:
  - state encoding fetch_state_t (IDLE=2'd0, RUN=2'd1, HALT=2'd2).
  - NOP_WORD constant.
  - WORD_BYTES=4.
  - An if_id_t struct {instr, pc4, valid}, reused by the decode stage.
- One natural sub-module, if_id_reg: the IF/ID pipeline register with hold (stall) and bubble (flush) controls.
- PC logic and the FSM stay in instruction_fetch.

Test Plan:
- Reset then start=1, no stall/redirect, word at 0 = 32'h8D09_0000:
  - cycle after RUN entry: pc=0.
  - next edge: if_id_instr=32'h8D09_0000, if_id_pc4=4, valid=1, pc=4.
- stall=1 for 3 cycles at pc=8: pc stays 8 and IF/ID unchanged all 3 cycles; on release the next edge loads the word at 8, pc=12.
- redirect=1 with redirect_pc=32'h16 at pc=20, stall=1 simultaneously:
  - pc=0x14 (aligned target); IF/ID=NOP_WORD, valid=0.
  - next edge: fetch from 0x14.
- Run to pc=76, then advance: pc=80 -> next edge halted=1, IF/ID bubble.
  - redirect to 0x100: still halted.
  - redirect to 0x8: RUN, pc=8.
- Assert rst_n=0 asynchronously mid-cycle while pc=36: pc=0, valid=0, state IDLE immediately, without waiting for a clock edge.
- With FETCH_PERF_EN: 5 advances + 2 redirects -> fetch_count=5, squash_count=2.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU types and constants for the fetch and decode stages.
package cpu_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HALT = 2'd2} fetch_state_t;
    localparam logic [31:0] NOP_WORD = 32'h0000_0020;
    localparam logic [31:0] WORD_BYTES = 32'd4;
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
    } if_id_t;
endpackage

// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if: control, instruction-memory and IF/ID signals of the fetch stage.
interface instruction_fetch_if;
    logic        start;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic [31:0] pc;
    logic        halted;
    modport slave (
        input  start, stall, redirect, redirect_pc, imem_instr,
        output imem_addr, if_id_instr, if_id_pc4, if_id_valid, pc, halted
    );
    modport master (
        output start, stall, redirect, redirect_pc, imem_instr,
        input  imem_addr, if_id_instr, if_id_pc4, if_id_valid, pc, halted
    );
endinterface

// File: rtl/instruction_fetch_if_id_reg.sv
// if_id_reg: IF/ID pipeline register; flush (bubble) takes priority over hold.
module if_id_reg
    import cpu_pkg::*;
#(
    parameter logic [31:0] BUBBLE_INSTR = NOP_WORD
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   hold_i,
    input  logic   flush_i,
    input  if_id_t d_i,
    output if_id_t q_o
);
    if_id_t q_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)       q_q <= '{instr: BUBBLE_INSTR, pc4: '0, valid: 1'b0};
        else if (flush_i) q_q <= '{instr: BUBBLE_INSTR, pc4: '0, valid: 1'b0};
        else if (!hold_i) q_q <= d_i;
    assign q_o = q_q;
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC/FSM of the fetch stage feeding the IF/ID register.
// Optional FETCH_PERF_EN adds saturating fetch_count/squash_count outputs.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_BYTES = 80,
    parameter logic [31:0] NOP_WORD  = cpu_pkg::NOP_WORD
) (
    input  logic                clk,
    input  logic                rst_n,
    instruction_fetch_if.slave  bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]         fetch_count,
    output logic [31:0]         squash_count
`endif
);
    cpu_pkg::fetch_state_t state_q, state_d;
    logic [31:0] pc_q, pc_d, tgt;
    logic hold, flush, adv, squash;
    cpu_pkg::if_id_t if_id_d, if_id_q;
    assign tgt = bus.redirect_pc & ~32'h3;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q <= cpu_pkg::IDLE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    // Anything other than a stall or advance in RUN loads a bubble into IF/ID.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        flush   = 1'b1;
        hold    = 1'b0;
        adv     = 1'b0;
        squash  = 1'b0;
        case (state_q)
            cpu_pkg::IDLE: state_d = bus.start ? cpu_pkg::RUN : cpu_pkg::IDLE;
            cpu_pkg::RUN:
                if (bus.redirect) begin
                    pc_d   = tgt;
                    squash = 1'b1;
                end else if (pc_q >= 32'(MEM_BYTES)) begin
                    state_d = cpu_pkg::HALT;
                end else if (bus.stall) begin
                    hold  = 1'b1;
                    flush = 1'b0;
                end else begin
                    adv   = 1'b1;
                    flush = 1'b0;
                    pc_d  = pc_q + cpu_pkg::WORD_BYTES;
                end
            cpu_pkg::HALT:
                if (bus.redirect && tgt < 32'(MEM_BYTES)) begin
                    state_d = cpu_pkg::RUN;
                    pc_d    = tgt;
                end
            default: state_d = cpu_pkg::IDLE;
        endcase
    end
    assign if_id_d = '{instr: bus.imem_instr, pc4: pc_q + cpu_pkg::WORD_BYTES, valid: 1'b1};
    if_id_reg #(.BUBBLE_INSTR(NOP_WORD)) u_if_id (
        .clk    (clk),
        .rst_n  (rst_n),
        .hold_i (hold),
        .flush_i(flush),
        .d_i    (if_id_d),
        .q_o    (if_id_q)
    );
    assign bus.imem_addr   = pc_q;
    assign bus.pc          = pc_q;
    assign bus.halted      = state_q == cpu_pkg::HALT;
    assign bus.if_id_instr = if_id_q.instr;
    assign bus.if_id_pc4   = if_id_q.pc4;
    assign bus.if_id_valid = if_id_q.valid;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count_q, squash_count_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            fetch_count_q  <= '0;
            squash_count_q <= '0;
        end else begin
            if (adv && ~&fetch_count_q)     fetch_count_q  <= fetch_count_q + 32'd1;
            if (squash && ~&squash_count_q) squash_count_q <= squash_count_q + 32'd1;
        end
    assign fetch_count  = fetch_count_q;
    assign squash_count = squash_count_q;
`endif
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed checks of the fetch stage against hand-computed values.
module tb_instruction_fetch;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int n_checks = 0;
    int n_fails = 0;
    logic [31:0] mem [20];
    localparam logic [31:0] NOP = 32'h0000_0020;
    instruction_fetch_if bus();
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count, squash_count;
`endif
    instruction_fetch dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
`ifdef FETCH_PERF_EN
        ,
        .fetch_count (fetch_count),
        .squash_count(squash_count)
`endif
    );
    always #5 clk = ~clk;
    assign bus.imem_instr = (bus.imem_addr < 32'd80) ? mem[bus.imem_addr[6:2]] : 32'h0;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    initial begin
        mem[0] = 32'h8D09_0000;
        for (int i = 1; i < 20; i++) mem[i] = 32'h1000_0000 + 32'(i);
        bus.start = 1'b0;
        bus.stall = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_pc = '0;
        #1 rst_n = 1'b0;
        #2;
        check("rst_pc", bus.pc, 32'h0);
        check("rst_addr", bus.imem_addr, 32'h0);
        check("rst_instr", bus.if_id_instr, NOP);
        check("rst_pc4", bus.if_id_pc4, 32'h0);
        check("rst_valid", 32'(bus.if_id_valid), 32'h0);
        check("rst_halted", 32'(bus.halted), 32'h0);
        @(negedge clk) rst_n = 1'b1;
        tick();
        check("idle_pc", bus.pc, 32'h0);
        check("idle_valid", 32'(bus.if_id_valid), 32'h0);
        bus.start = 1'b1;
        tick();
        check("run_entry_pc", bus.pc, 32'h0);
        check("run_entry_valid", 32'(bus.if_id_valid), 32'h0);
        tick();
        check("f0_instr", bus.if_id_instr, 32'h8D09_0000);
        check("f0_pc4", bus.if_id_pc4, 32'h4);
        check("f0_valid", 32'(bus.if_id_valid), 32'h1);
        check("f0_pc", bus.pc, 32'h4);
        bus.start = 1'b0;
        tick();
        check("f1_pc", bus.pc, 32'h8);
        check("f1_instr", bus.if_id_instr, 32'h1000_0001);
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_pc", bus.pc, 32'h8);
            check("stall_instr", bus.if_id_instr, 32'h1000_0001);
            check("stall_pc4", bus.if_id_pc4, 32'h8);
            check("stall_valid", 32'(bus.if_id_valid), 32'h1);
        end
        bus.stall = 1'b0;
        tick();
        check("unstall_instr", bus.if_id_instr, 32'h1000_0002);
        check("unstall_pc4", bus.if_id_pc4, 32'hC);
        check("unstall_pc", bus.pc, 32'hC);
        tick();
        tick();
        check("pre_redir_pc", bus.pc, 32'h14);
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h16;
        bus.stall = 1'b1;
        tick();
        check("redir_pc", bus.pc, 32'h14);
        check("redir_instr", bus.if_id_instr, NOP);
        check("redir_valid", 32'(bus.if_id_valid), 32'h0);
        bus.redirect = 1'b0;
        bus.stall = 1'b0;
        tick();
        check("post_redir_instr", bus.if_id_instr, 32'h1000_0005);
        check("post_redir_pc4", bus.if_id_pc4, 32'h18);
        check("post_redir_pc", bus.pc, 32'h18);
        for (int i = 0; i < 14; i++) tick();
        check("end_pc", bus.pc, 32'd80);
        check("end_instr", bus.if_id_instr, 32'h1000_0013);
        check("end_pc4", bus.if_id_pc4, 32'd80);
        check("end_halted", 32'(bus.halted), 32'h0);
        tick();
        check("halt_flag", 32'(bus.halted), 32'h1);
        check("halt_instr", bus.if_id_instr, NOP);
        check("halt_valid", 32'(bus.if_id_valid), 32'h0);
        check("halt_pc", bus.pc, 32'd80);
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h100;
        tick();
        check("halt_far_flag", 32'(bus.halted), 32'h1);
        check("halt_far_pc", bus.pc, 32'd80);
        bus.redirect_pc = 32'h8;
        tick();
        check("resume_flag", 32'(bus.halted), 32'h0);
        check("resume_pc", bus.pc, 32'h8);
        check("resume_valid", 32'(bus.if_id_valid), 32'h0);
        bus.redirect = 1'b0;
        tick();
        check("resume_instr", bus.if_id_instr, 32'h1000_0002);
        check("resume_next_pc", bus.pc, 32'hC);
        for (int i = 0; i < 6; i++) tick();
        check("pre_arst_pc", bus.pc, 32'd36);
        check("pre_arst_valid", 32'(bus.if_id_valid), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_pc", bus.pc, 32'h0);
        check("arst_valid", 32'(bus.if_id_valid), 32'h0);
        check("arst_instr", bus.if_id_instr, NOP);
        check("arst_halted", 32'(bus.halted), 32'h0);
        @(negedge clk) rst_n = 1'b1;
        tick();
        tick();
        check("arst_idle_pc", bus.pc, 32'h0);
        check("arst_idle_valid", 32'(bus.if_id_valid), 32'h0);
`ifdef FETCH_PERF_EN
        check("perf_rst_fetch", fetch_count, 32'h0);
        check("perf_rst_squash", squash_count, 32'h0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h0;
        tick();
        tick();
        bus.redirect = 1'b0;
        check("perf_fetch", fetch_count, 32'd5);
        check("perf_squash", squash_count, 32'd2);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
